// File: rtl/mem_arbiter_pkg.sv
// Shared types and address-map constants for the RAM/terminal bus arbiter.
// Region and owner enums are shared by the decoder, the arbiter and anything that snoops the return path.
package mem_arbiter_pkg;

    localparam logic [31:0] RAM_LIMIT  = 32'h1000_0000;
    localparam logic [31:0] TERM_BASE  = 32'hA000_0000;
    localparam logic [31:0] TERM_SPAN  = 32'h0100_0000;
    localparam int          TERM_CHARS = 2100;
    localparam int          TERM_AW    = 12;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_TERM,
        REGION_ERR
    } region_e;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IF,
        OWNER_DM_RAM,
        OWNER_DM_ZERO
    } owner_e;

    function automatic logic owner_is_dm(input owner_e owner);
        return (owner == OWNER_DM_RAM) || (owner == OWNER_DM_ZERO);
    endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational decode of a data-side address into RAM / terminal / error region.
// Also yields the terminal cell offset and whether it lies past the last visible cell.
module mem_addr_decode #(
    parameter logic [31:0] TERM_BASE  = mem_arbiter_pkg::TERM_BASE,
    parameter int          TERM_CHARS = mem_arbiter_pkg::TERM_CHARS
) (
    input  logic [31:0]               addr,
    output mem_arbiter_pkg::region_e  region,
    output logic [11:0]               term_off,
    output logic                      term_oob
);
    import mem_arbiter_pkg::*;

    logic [31:0] offset;

    always_comb begin
        offset = addr - TERM_BASE;
        region = REGION_ERR;
        // The base compare guards against the subtraction wrapping for addresses below the window.
        if (addr < RAM_LIMIT) begin
            region = REGION_RAM;
        end else if ((addr >= TERM_BASE) && (offset < TERM_SPAN)) begin
            region = REGION_TERM;
        end
        term_off = offset[11:0];
        term_oob = (offset >= 32'(TERM_CHARS));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and data access,
// steers data writes to the terminal buffer and returns read data one cycle after grant.
module mem_arbiter #(
    parameter int          RAM_AW     = 12,
    parameter logic [31:0] TERM_BASE  = mem_arbiter_pkg::TERM_BASE,
    parameter int          TERM_CHARS = mem_arbiter_pkg::TERM_CHARS,
    parameter int          MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              term_we,
    output logic [11:0]       term_addr,
    output logic [7:0]        term_wdata,
    output logic              bus_err
);
    import mem_arbiter_pkg::*;

    localparam logic [2:0] WAIT_SAT = 3'(MAX_WAIT);
    localparam int         NPORTS   = 2;

    region_e     dm_region;
    logic [11:0] dm_term_off;
    logic        dm_term_oob;

    logic        if_v;
    logic        dm_v;
    logic        dm_ram;
    logic        if_wins;

    logic [2:0]  starve_cnt;
    logic [2:0]  starve_next;
    owner_e      owner_q;
    owner_e      owner_next;
    logic        if_ret_q;
    logic        if_ret_next;
    logic        bus_err_q;
    logic        bus_err_next;

    logic        ret_valid [NPORTS];
    logic [31:0] ret_data  [NPORTS];
    logic [31:0] ret_out   [NPORTS];

    logic        unused_if_addr;
    assign unused_if_addr = ^{if_addr[31:RAM_AW+2], if_addr[1:0]};

    mem_addr_decode #(
        .TERM_BASE  (TERM_BASE),
        .TERM_CHARS (TERM_CHARS)
    ) u_decode (
        .addr     (dm_addr),
        .region   (dm_region),
        .term_off (dm_term_off),
        .term_oob (dm_term_oob)
    );

    // Requests are masked while reset is held so every output reads zero.
    assign if_v    = if_req & rst_n;
    assign dm_v    = dm_req & rst_n;
    assign dm_ram  = dm_v && (dm_region == REGION_RAM);
    assign if_wins = (starve_cnt == WAIT_SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            owner_q    <= OWNER_NONE;
            if_ret_q   <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            owner_q    <= owner_next;
            if_ret_q   <= if_ret_next;
            bus_err_q  <= bus_err_next;
        end
    end

    always_comb begin
        starve_next = '0;
        if (if_v && !if_gnt) begin
            starve_next = if_wins ? starve_cnt : starve_cnt + 3'd1;
        end

        owner_next = OWNER_NONE;
        if (dm_gnt && !dm_we) begin
            owner_next = dm_ram ? OWNER_DM_RAM : OWNER_DM_ZERO;
        end else if (if_gnt) begin
            owner_next = OWNER_IF;
        end
        if_ret_next = if_gnt;

        bus_err_next = dm_gnt && ((dm_region == REGION_ERR) ||
                       ((dm_region == REGION_TERM) && dm_we && dm_term_oob));
    end

    always_comb begin
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        term_we    = 1'b0;
        term_addr  = '0;
        term_wdata = '0;

        if (dm_ram && if_v) begin
            if_gnt = if_wins;
            dm_gnt = !if_wins;
        end else begin
            if_gnt = if_v;
            dm_gnt = dm_v;
        end

        if (dm_gnt && dm_ram) begin
            ram_en    = 1'b1;
            ram_we    = dm_we;
            ram_addr  = dm_addr[RAM_AW+1:2];
            ram_wdata = dm_wdata;
        end else if (if_gnt) begin
            ram_en   = 1'b1;
            ram_addr = if_addr[RAM_AW+1:2];
        end

        if (dm_gnt && dm_we && (dm_region == REGION_TERM) && !dm_term_oob) begin
            term_we    = 1'b1;
            term_addr  = dm_term_off;
            term_wdata = dm_wdata[7:0];
        end
    end

    // Port 0 is fetch, port 1 is data; each keeps its last returned word between strobes.
    assign ret_valid[0] = if_ret_q;
    assign ret_data[0]  = ram_rdata;
    assign ret_valid[1] = owner_is_dm(owner_q);
    assign ret_data[1]  = (owner_q == OWNER_DM_RAM) ? ram_rdata : 32'h0;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_ret
            logic [31:0] hold_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else if (ret_valid[gi]) begin
                    hold_reg <= ret_data[gi];
                end
            end

            assign ret_out[gi] = ret_valid[gi] ? ret_data[gi] : hold_reg;
        end
    endgenerate

    assign if_rvalid = ret_valid[0];
    assign if_rdata  = ret_out[0];
    assign dm_rvalid = ret_valid[1];
    assign dm_rdata  = ret_out[1];
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized check of mem_arbiter against a cycle-level model built from the arbitration rules.
module tb_mem_arbiter;

    localparam int RAM_AW   = 12;
    localparam int DEPTH    = 4096;
    localparam int MAX_WAIT = 4;
    localparam int PRELOAD  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [31:0]       dm_addr = '0;
    logic [31:0]       dm_wdata = '0;
    logic              dm_gnt, dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              ram_en, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;
    logic              term_we;
    logic [11:0]       term_addr;
    logic [7:0]        term_wdata;
    logic              bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .RAM_AW     (RAM_AW),
        .TERM_BASE  (32'hA000_0000),
        .TERM_CHARS (2100),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .term_we    (term_we),
        .term_addr  (term_addr),
        .term_wdata (term_wdata),
        .bus_err    (bus_err)
    );

    // Environment RAM: one-cycle read latency, plus a preload port used while reset is held.
    logic [31:0]       tb_ram [DEPTH];
    logic              pre_en = 1'b0;
    logic [RAM_AW-1:0] pre_addr = '0;
    logic [31:0]       pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            tb_ram[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] <= ram_wdata;
            ram_rdata <= tb_ram[ram_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          waits;
    logic        exp_if_v, exp_dm_v, exp_err;
    logic [31:0] exp_if_d, exp_dm_d, last_if_d, last_dm_d;
    logic        e_ig, e_dg;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_reset();
        waits     = 0;
        exp_if_v  = 1'b0;
        exp_dm_v  = 1'b0;
        exp_err   = 1'b0;
        exp_if_d  = '0;
        exp_dm_d  = '0;
        last_if_d = '0;
        last_dm_d = '0;
        e_ig      = 1'b0;
        e_dg      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnts"}, {30'd0, if_gnt, dm_gnt}, 32'd0);
        check({tag, "_rvalids"}, {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        check({tag, "_ram_ctl"}, {30'd0, ram_en, ram_we}, 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_term"}, {19'd0, term_we, term_addr}, 32'd0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    // One bus cycle: inputs already driven at the falling edge; check, advance the model, step the clock.
    task automatic cycle();
        logic        dm_ram_t, dm_term_t, e_twe, e_ram_en;
        logic [31:0] toff;
        #1;
        n_cyc++;
        $display("txn %0d: if req=%0b a=%08h | dm req=%0b we=%0b a=%08h wd=%08h | gnt if=%0b dm=%0b",
                 n_cyc, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, if_gnt, dm_gnt);

        check("if_rvalid", 32'(if_rvalid), 32'(exp_if_v));
        check(exp_if_v ? "if_rdata" : "if_rdata_hold", if_rdata, exp_if_v ? exp_if_d : last_if_d);
        check("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm_v));
        check(exp_dm_v ? "dm_rdata" : "dm_rdata_hold", dm_rdata, exp_dm_v ? exp_dm_d : last_dm_d);
        check("bus_err", 32'(bus_err), 32'(exp_err));

        dm_ram_t  = dm_req && (dm_addr < 32'h1000_0000);
        dm_term_t = dm_req && (dm_addr >= 32'hA000_0000) && (dm_addr < 32'hA100_0000);
        toff      = dm_addr - 32'hA000_0000;
        if (if_req && dm_ram_t) begin
            e_ig = (waits == MAX_WAIT);
            e_dg = !e_ig;
        end else begin
            e_ig = if_req;
            e_dg = dm_req;
        end
        e_twe    = e_dg && dm_we && dm_term_t && (toff < 2100);
        e_ram_en = e_ig || (e_dg && dm_ram_t);

        check("if_gnt", 32'(if_gnt), 32'(e_ig));
        check("dm_gnt", 32'(dm_gnt), 32'(e_dg));
        check("term_we", 32'(term_we), 32'(e_twe));
        if (e_twe) begin
            check("term_addr", 32'(term_addr), toff);
            check("term_wdata", 32'(term_wdata), dm_wdata & 32'hFF);
        end
        check("ram_en", 32'(ram_en), 32'(e_ram_en));
        if (e_ram_en) begin
            if (e_dg && dm_ram_t) begin
                check("ram_addr_dm", 32'(ram_addr), 32'(word_of(dm_addr)));
                check("ram_we", 32'(ram_we), 32'(dm_we));
                if (dm_we) check("ram_wdata", ram_wdata, dm_wdata);
            end else begin
                check("ram_addr_if", 32'(ram_addr), 32'(word_of(if_addr)));
                check("ram_we_if", 32'(ram_we), 32'd0);
            end
        end

        if (exp_if_v) last_if_d = exp_if_d;
        if (exp_dm_v) last_dm_d = exp_dm_d;
        exp_if_v = e_ig;
        if (e_ig) exp_if_d = ref_mem[word_of(if_addr)];
        exp_dm_v = e_dg && !dm_we;
        if (exp_dm_v) exp_dm_d = dm_ram_t ? ref_mem[word_of(dm_addr)] : 32'h0;
        if (e_dg && dm_we && dm_ram_t) ref_mem[word_of(dm_addr)] = dm_wdata;
        exp_err = e_dg && !dm_ram_t && (!dm_term_t || (dm_we && toff >= 2100));
        if (if_req && !e_ig) waits = (waits < MAX_WAIT) ? waits + 1 : MAX_WAIT;
        else waits = 0;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dd;
    endtask

    function automatic logic [31:0] rand_dm_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return ($urandom_range(0, PRELOAD-1) << 2) | ($urandom & 32'h0FFF_0003);
            3:       return 32'hA000_0000 + $urandom_range(0, 2099);
            4:       return 32'hA000_0000 + $urandom_range(2100, 32'h00FF_FFFF);
            5:       return 32'h1000_0000 + $urandom_range(0, 32'h8FFF_FFFF);
            6:       return 32'hA100_0000 + $urandom_range(0, 32'h0FFF_FFFF);
            default: return 32'hA000_0000 + ($urandom_range(0, 1) == 0 ? 32'd2099 : 32'd2100);
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        model_reset();
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h8, '0);
        @(negedge clk);
        check_all_zero("reset");

        for (int i = 0; i < PRELOAD; i++) begin
            v = (i == 4) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = v;
            pre_en   = 1'b1;
            pre_addr = RAM_AW'(i);
            pre_data = v;
            @(negedge clk);
        end
        pre_en = 1'b0;
        check_all_zero("reset_hold");

        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        cycle();

        // Fetch only from word 4
        drive(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Both requesters hammer RAM reads: fetch wins every fifth cycle
        drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h30, '0);
        repeat (15) cycle();

        // Terminal write alongside a fetch
        drive(1'b1, 32'h0, 1'b1, 1'b1, 32'hA000_0005, 32'h0000_0041);
        cycle();
        // Last visible cell, then first cell past the end
        drive(1'b0, '0, 1'b1, 1'b1, 32'hA000_0833, 32'h0000_0055);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b1, 32'hA000_0834, 32'h0000_0042);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0, 32'h2000_0000, '0);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0, 32'hA000_0010, '0);
        cycle();

        // Write then read back through RAM
        drive(1'b0, '0, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
        cycle();
        drive(1'b0, '0, 1'b1, 1'b0, 32'h8, '0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cycle();

        // Reset hits after the grant, before the return is registered
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h8, '0);
        #1;
        check("pre_rst_dm_gnt", 32'(dm_gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_mid_held");
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        model_reset();
        cycle();
        cycle();

        // Randomized traffic: requests are held until granted, occasionally dropped
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 1500; n++) begin
            if (!if_req || e_ig || $urandom_range(0, 9) == 0) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = ($urandom_range(0, PRELOAD-1) << 2) | ($urandom & 32'hF000_0003);
            end
            if (!dm_req || e_dg || $urandom_range(0, 9) == 0) begin
                dm_req   = ($urandom_range(0, 3) != 0);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = rand_dm_addr();
                dm_wdata = $urandom;
            end
            cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
